// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display stage.
//   state_e       : conversion FSM states
//   SEG_*         : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   BCD_SHIFTS    : number of double-dabble shifts for an 8-bit binary input
//   add3_nibbles  : double-dabble correction applied to the three BCD nibbles
package calc_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned RESULT_W   = 8;
  localparam int unsigned SR_W       = 20;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BCD_SHIFTS = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // A nibble of 5..9 becomes 8..12 so the following shift carries into the next digit.
  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Correct hundreds [19:16], tens [15:12] and ones [11:8]; binary part is untouched.
  function automatic logic [SR_W-1:0] add3_nibbles(input logic [SR_W-1:0] sr);
    return {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
  endfunction

endpackage

// File: rtl/calc_result_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 are blank.
//   digit : 4-bit digit code
//   seg_c : {g,f,e,d,c,b,a}, active-low (combinational)
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_result_display.sv
// Captures the calculator result and flags, converts the result to BCD with a
// sequential double-dabble engine and drives a 4-digit multiplexed display.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture request, honoured only when idle
//   result      : unsigned 8-bit value to display
//   overflow    : overflow flag (ignored for multiply)
//   carry_out   : carry flag (ignored for multiply)
//   op_sel      : opcode; bit 1 set means multiply
//   busy        : conversion in progress
//   bcd_valid   : display holds the most recent accepted load
//   seg, dp, an : active-low segments, decimal point and digit anodes
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [RESULT_W-1:0] result,
  input  logic                overflow,
  input  logic                carry_out,
  input  logic [1:0]          op_sel,
  output logic                busy,
  output logic                bcd_valid,
  output logic [SEG_W-1:0]    seg,
  output logic                dp,
  output logic [AN_W-1:0]     an
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);

  state_e               state, state_d;
  logic [SR_W-1:0]      sr, sr_d;
  logic [SR_W-1:0]      sr_adj_c;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 flag_ov, flag_ov_d;
  logic                 flag_c, flag_c_d;
  logic [DIGIT_W-1:0]   disp_h, disp_h_d;
  logic [DIGIT_W-1:0]   disp_t, disp_t_d;
  logic [DIGIT_W-1:0]   disp_o, disp_o_d;
  logic                 disp_ov, disp_ov_d;
  logic                 disp_c, disp_c_d;
  logic                 bcd_valid_d;
  logic                 busy_d;

  logic [REF_W-1:0]     ref_cnt;
  logic [1:0]           digit_idx;
  logic [DIGIT_W-1:0]   digit_sel_c;
  logic [SEG_W-1:0]     digit_seg_c;

  assign sr_adj_c = add3_nibbles(sr);

  // FSM and conversion datapath state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sr        <= '0;
      cnt       <= '0;
      flag_ov   <= 1'b0;
      flag_c    <= 1'b0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_o    <= '0;
      disp_ov   <= 1'b0;
      disp_c    <= 1'b0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      cnt       <= cnt_d;
      flag_ov   <= flag_ov_d;
      flag_c    <= flag_c_d;
      disp_h    <= disp_h_d;
      disp_t    <= disp_t_d;
      disp_o    <= disp_o_d;
      disp_ov   <= disp_ov_d;
      disp_c    <= disp_c_d;
      bcd_valid <= bcd_valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state;
    sr_d        = sr;
    cnt_d       = cnt;
    flag_ov_d   = flag_ov;
    flag_c_d    = flag_c;
    disp_h_d    = disp_h;
    disp_t_d    = disp_t;
    disp_o_d    = disp_o;
    disp_ov_d   = disp_ov;
    disp_c_d    = disp_c;
    bcd_valid_d = bcd_valid;

    case (state)
      ST_IDLE: begin
        if (load) begin
          sr_d        = {12'b0, result};
          cnt_d       = '0;
          flag_ov_d   = overflow & ~op_sel[1];
          flag_c_d    = carry_out & ~op_sel[1];
          bcd_valid_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = {sr_adj_c[SR_W-2:0], 1'b0};
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BCD_SHIFTS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_h_d    = sr[19:16];
        disp_t_d    = sr[15:12];
        disp_o_d    = sr[11:8];
        disp_ov_d   = flag_ov;
        disp_c_d    = flag_c;
        bcd_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Refresh timer and digit index; free-running regardless of the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      ref_cnt   <= ref_cnt + REF_W'(1);
    end
  end

  always_comb begin
    digit_sel_c = disp_o;
    case (digit_idx)
      2'd0:    digit_sel_c = disp_o;
      2'd1:    digit_sel_c = disp_t;
      2'd2:    digit_sel_c = disp_h;
      default: digit_sel_c = disp_o;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (digit_sel_c),
    .seg_c (digit_seg_c)
  );

  // Registered display drive; the leftmost position is the error indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_0;
      an  <= 4'b1110;
      dp  <= 1'b1;
    end else begin
      seg <= (digit_idx == 2'd3) ? (disp_ov ? SEG_E : SEG_BLANK) : digit_seg_c;
      an  <= ~(4'b0001 << digit_idx);
      dp  <= ~((digit_idx == 2'd0) & disp_c);
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
module tb_calc_result_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] result;
  logic       overflow;
  logic       carry_out;
  logic [1:0] op_sel;
  logic       busy;
  logic       bcd_valid;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] result;
    logic       ov;
    logic       c;
    logic [1:0] op;
    int         h;
    int         t;
    int         o;
    bit         show_e;
    bit         show_dp;
  } vec_t;

  calc_result_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .result    (result),
    .overflow  (overflow),
    .carry_out (carry_out),
    .op_sel    (op_sel),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Starts a conversion and returns the number of sampled busy cycles.
  task automatic do_load(input logic [7:0] r, input logic ov, input logic c,
                         input logic [1:0] op, output int busy_cycles);
    result = r; overflow = ov; carry_out = c; op_sel = op; load = 1'b1;
    step();
    load = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 30) begin
      busy_cycles++;
      step();
    end
  endtask

  // Watches the scanned display for 16 cycles and compares every position.
  task automatic check_display(input string name, input int h, input int t, input int o,
                               input bit show_e, input bit show_dp, input bit exp_valid);
    logic [6:0] es;
    logic       edp;
    bit         legal;
    logic [3:0] seen;
    seen = '0;
    step();
    for (int i = 0; i < 16; i++) begin
      legal = 1'b1;
      edp   = 1'b1;
      es    = 7'b1111111;
      case (an)
        4'b1110: begin es = seg_of(o); edp = ~show_dp; seen[0] = 1'b1; end
        4'b1101: begin es = seg_of(t); seen[1] = 1'b1; end
        4'b1011: begin es = seg_of(h); seen[2] = 1'b1; end
        4'b0111: begin es = show_e ? 7'b0000110 : 7'b1111111; seen[3] = 1'b1; end
        default: legal = 1'b0;
      endcase
      checks++;
      if (!legal || seg !== es || dp !== edp || bcd_valid !== exp_valid) begin
        failures++;
        $display("FAIL %s cyc=%0d an=%b seg=%b dp=%b valid=%b required seg=%b dp=%b valid=%b",
                 name, i, an, seg, dp, bcd_valid, es, edp, exp_valid);
      end
      if (i != 15) step();
    end
    check({name, "_all_digits_scanned"}, int'(seen), 15);
  endtask

  vec_t vecs[4];
  int   bc;

  initial begin
    logic [3:0] prev_an;
    int         run_len;
    int         runs;
    int         t0;
    int         t1;
    int         n;

    rst_n = 1'b0; load = 1'b0; result = '0; overflow = 1'b0; carry_out = 1'b0; op_sel = '0;

    // Reset values
    step();
    step();
    check("reset_an", int'(an), 4'b1110);
    check("reset_seg", int'(seg), 7'b1000000);
    check("reset_dp", int'(dp), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(bcd_valid), 0);
    rst_n = 1'b1;

    // Refresh rotation: every complete hold is 4 cycles in order 0->1->2->3
    prev_an = an; run_len = 1; runs = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (an != prev_an) begin
        if (runs > 0) check("refresh_hold_len", run_len, 4);
        check("refresh_order", int'(an), int'({prev_an[2:0], prev_an[3]}));
        runs++;
        run_len = 1;
        prev_an = an;
      end else begin
        run_len++;
      end
    end
    check("refresh_valid_low", int'(bcd_valid), 0);
    check_display("reset_display", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Table-driven vectors
    vecs[0] = '{8'd225, 1'b0, 1'b0, 2'b11, 2, 2, 5, 1'b0, 1'b0};
    vecs[1] = '{8'd255, 1'b1, 1'b1, 2'b01, 2, 5, 5, 1'b1, 1'b1};
    vecs[2] = '{8'd255, 1'b1, 1'b1, 2'b10, 2, 5, 5, 1'b0, 1'b0};
    vecs[3] = '{8'd0,   1'b1, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].result, vecs[v].ov, vecs[v].c, vecs[v].op, bc);
      check($sformatf("vec%0d_busy_cycles", v), bc, 9);
      check($sformatf("vec%0d_valid_at_done", v), int'(bcd_valid), 1);
      check_display($sformatf("vec%0d", v), vecs[v].h, vecs[v].t, vecs[v].o,
                    vecs[v].show_e, vecs[v].show_dp, 1'b1);
    end

    // Load while busy is ignored
    result = 8'd7; overflow = 1'b0; carry_out = 1'b0; op_sel = 2'b00; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    result = 8'd200; load = 1'b1;
    step();
    load = 1'b0; result = 8'd0;
    n = 3;
    while (busy && n < 30) begin n++; step(); end
    check("busy_load_ignored_len", n, 9);
    check_display("busy_load_ignored", 0, 0, 7, 1'b0, 1'b0, 1'b1);

    // Load held high restarts every 10 cycles; final value shown
    result = 8'd42; overflow = 1'b0; carry_out = 1'b0; op_sel = 2'b00; load = 1'b1;
    n = 0;
    while (!busy && n < 5) begin n++; step(); end
    t0 = cyc;
    n = 0;
    while (busy && n < 20) begin n++; step(); end
    n = 0;
    while (!busy && n < 20) begin n++; step(); end
    t1 = cyc;
    check("held_load_period", t1 - t0, 10);
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; step(); end
    check_display("held_load", 0, 4, 2, 1'b0, 1'b0, 1'b1);

    // Randomized against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      logic [7:0] rv;
      logic       rov, rc;
      logic [1:0] rop;
      rv = 8'($urandom_range(0, 255)); rov = 1'($urandom); rc = 1'($urandom); rop = 2'($urandom);
      do_load(rv, rov, rc, rop, bc);
      check($sformatf("rand%0d_busy_cycles", r), bc, 9);
      check_display($sformatf("rand%0d_val%0d", r, rv), int'(rv) / 100, (int'(rv) / 10) % 10,
                    int'(rv) % 10, rov & ~rop[1], rc & ~rop[1], 1'b1);
    end

    // Reset in the middle of a conversion
    result = 8'd99; overflow = 1'b1; carry_out = 1'b1; op_sel = 2'b00; load = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("midreset_an", int'(an), 4'b1110);
    check("midreset_seg", int'(seg), 7'b1000000);
    check("midreset_dp", int'(dp), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(bcd_valid), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("midreset_no_done_busy", int'(busy), 0);
    check_display("midreset_display", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
